// File: rtl/interleave.sv
// OFDM transmit interleaver (802.11a/g legacy and 802.11n HT 20 MHz) with a ping-pong
// symbol buffer: bits are permuted on write, then drained one subcarrier per strobe.
module interleave (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] rate,
    input  logic       in_bit,
    input  logic       input_strobe,
    output logic       in_ready,
    input  logic       output_ready,
    output logic [5:0] out_bits,
    output logic       output_strobe
);

    typedef enum logic {W_FILL0, W_FILL1} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_HOLD} rstate_t;

    // Mode word is {ht, N_BPSC}; unknown codes fall back to BPSK.
    function automatic logic [3:0] decode_mode(input logic ht, input logic [3:0] code);
        logic [2:0] nb;
        nb = 3'd1;
        if (ht) begin
            case (code)
                4'd1, 4'd2:       nb = 3'd2;
                4'd3, 4'd4:       nb = 3'd4;
                4'd5, 4'd6, 4'd7: nb = 3'd6;
                default:          nb = 3'd1;
            endcase
        end else begin
            case (code)
                4'b1010, 4'b1110: nb = 3'd2;
                4'b1001, 4'b1101: nb = 3'd4;
                4'b1000, 4'b1100: nb = 3'd6;
                default:          nb = 3'd1;
            endcase
        end
        return {ht, nb};
    endfunction

    logic         unused_rate;
    logic [311:0] mem [2];
    logic [3:0]   bank_mode [2];
    logic [1:0]   full;

    wstate_t    wstate;
    logic       wbank, first, accept, last_bit;
    logic [3:0] col, w_col_last;
    logic [4:0] row, w_nrow, w_row_last, nb5;
    logic [8:0] ibase, i_idx, j_idx;
    logic [1:0] rm3, cm3, d3;
    logic [2:0] t3;
    logic [3:0] w_mode;

    assign unused_rate = ^rate[6:4];
    assign wbank    = (wstate == W_FILL1);
    assign in_ready = !full[wbank];
    assign accept   = enable && input_strobe && in_ready;
    assign first    = (col == 4'd0) && (row == 5'd0);
    assign w_mode   = first ? decode_mode(rate[7], rate[3:0]) : bank_mode[wbank];

    // N_ROW = 3*N_BPSC (legacy) or 4*N_BPSC (HT); N_COL*i/N_CBPS reduces to the column index.
    assign nb5        = {2'b00, w_mode[2:0]};
    assign w_nrow     = w_mode[3] ? (nb5 << 2) : ((nb5 << 1) + nb5);
    assign w_row_last = w_nrow - 5'd1;
    assign w_col_last = w_mode[3] ? 4'd12 : 4'd15;
    assign last_bit   = (col == w_col_last) && (row == w_row_last);
    assign i_idx      = ibase + {4'b0000, row};
    assign t3         = {1'b0, rm3} + 3'd3 - {1'b0, cm3};
    assign d3         = (t3 >= 3'd3) ? 2'(t3 - 3'd3) : t3[1:0];

    always_comb begin
        j_idx = i_idx;
        case (w_mode[2:0])
            3'd4:    j_idx = {i_idx[8:1], i_idx[0] ^ col[0]};
            3'd6:    j_idx = i_idx - {7'b0, rm3} + {7'b0, d3};
            default: j_idx = i_idx;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wstate <= W_FILL0;
            col    <= 4'd0;
            row    <= 5'd0;
            ibase  <= 9'd0;
            rm3    <= 2'd0;
            cm3    <= 2'd0;
        end else if (accept) begin
            if (col == w_col_last) begin
                col   <= 4'd0;
                cm3   <= 2'd0;
                ibase <= 9'd0;
                if (row == w_row_last) begin
                    row    <= 5'd0;
                    rm3    <= 2'd0;
                    wstate <= (wstate == W_FILL0) ? W_FILL1 : W_FILL0;
                end else begin
                    row <= row + 5'd1;
                    rm3 <= (rm3 == 2'd2) ? 2'd0 : rm3 + 2'd1;
                end
            end else begin
                col   <= col + 4'd1;
                cm3   <= (cm3 == 2'd2) ? 2'd0 : cm3 + 2'd1;
                ibase <= ibase + {4'b0000, w_nrow};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wbank][j_idx] <= in_bit;
            if (first) bank_mode[wbank] <= w_mode;
        end
    end

    rstate_t    rstate;
    logic       rbank, rd_bit, rd_last, handoff, sym_done;
    logic [8:0] raddr;
    logic [2:0] bcnt;
    logic [5:0] sc, r_sc_last, sc_bits, sc_bits_next;
    logic [3:0] r_mode;

    assign r_mode        = bank_mode[rbank];
    assign r_sc_last     = r_mode[3] ? 6'd51 : 6'd47;
    assign rd_bit        = mem[rbank][raddr];
    assign rd_last       = (bcnt == r_mode[2:0] - 3'd1);
    assign sc_bits_next  = sc_bits | (6'(rd_bit) << bcnt);
    assign handoff       = (rstate == R_HOLD) && output_ready && enable;
    assign sym_done      = handoff && (sc == r_sc_last);
    assign output_strobe = handoff;

    // A bank completed by the writer and a bank freed by the reader are never the same one.
    always_ff @(posedge clock) begin
        if (reset) begin
            full <= 2'b00;
        end else begin
            if (accept && last_bit) full[wbank] <= 1'b1;
            if (sym_done) full[rbank] <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rstate   <= R_IDLE;
            rbank    <= 1'b0;
            raddr    <= 9'd0;
            bcnt     <= 3'd0;
            sc       <= 6'd0;
            out_bits <= 6'd0;
        end else if (enable) begin
            case (rstate)
                R_IDLE: if (full[rbank]) rstate <= R_READ;
                R_READ: begin
                    raddr <= raddr + 9'd1;
                    if (rd_last) begin
                        bcnt     <= 3'd0;
                        out_bits <= sc_bits_next;
                        rstate   <= R_HOLD;
                    end else begin
                        bcnt <= bcnt + 3'd1;
                    end
                end
                R_HOLD: if (output_ready) begin
                    if (sc == r_sc_last) begin
                        sc     <= 6'd0;
                        raddr  <= 9'd0;
                        rbank  <= ~rbank;
                        rstate <= full[~rbank] ? R_READ : R_IDLE;
                    end else begin
                        sc     <= sc + 6'd1;
                        rstate <= R_READ;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (enable) begin
            if (rstate == R_READ && !rd_last) sc_bits <= sc_bits_next;
            else sc_bits <= 6'd0;
        end
    end

endmodule

// File: tb/tb_interleave.sv
// Directed bench for the OFDM interleaver: single-bit symbol table, then back-to-back,
// rate-switch, random enable/ready and mid-drain reset sequences against a golden model.
module tb_interleave;

    logic       clock = 1'b0;
    logic       reset, enable, in_bit, input_strobe, output_ready;
    logic [7:0] rate;
    logic       in_ready, output_strobe;
    logic [5:0] out_bits;

    always #5 clock = ~clock;

    interleave dut (
        .clock(clock), .reset(reset), .enable(enable), .rate(rate), .in_bit(in_bit),
        .input_strobe(input_strobe), .in_ready(in_ready), .output_ready(output_ready),
        .out_bits(out_bits), .output_strobe(output_strobe)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { logic [5:0] bits; int cyc; } obs_t;
    obs_t       obs[$];
    logic [5:0] exp_q[$];

    logic [311:0] m_bits = '0;
    logic [7:0]   m_rate = 8'h00;
    int           m_k = 0;
    int           n_acc = 0;
    int           last_acc = 0;

    function automatic int nb_of(input logic [7:0] r);
        if (r[7]) begin
            case (r[3:0])
                4'd1, 4'd2:       return 2;
                4'd3, 4'd4:       return 4;
                4'd5, 4'd6, 4'd7: return 6;
                default:          return 1;
            endcase
        end
        case (r[3:0])
            4'hA, 4'hE: return 2;
            4'h9, 4'hD: return 4;
            4'h8, 4'hC: return 6;
            default:    return 1;
        endcase
    endfunction

    function automatic int ncbps_of(input logic [7:0] r);
        return (r[7] ? 52 : 48) * nb_of(r);
    endfunction

    // Golden two-step permutation straight from the textbook formula.
    function automatic void build_exp(input logic [7:0] r, input logic [311:0] b);
        int nb, n, ncol, nrow, s, i, j;
        logic [311:0] o;
        logic [5:0] v;
        nb = nb_of(r);
        n = ncbps_of(r);
        ncol = r[7] ? 13 : 16;
        nrow = n / ncol;
        s = (nb / 2 < 1) ? 1 : nb / 2;
        o = '0;
        for (int k = 0; k < n; k++) begin
            i = nrow * (k % ncol) + k / ncol;
            j = s * (i / s) + (i + n - (ncol * i) / n) % s;
            o[j] = b[k];
        end
        for (int c = 0; c < n / nb; c++) begin
            v = '0;
            for (int bb = 0; bb < nb; bb++) v[bb] = o[c * nb + bb];
            exp_q.push_back(v);
        end
    endfunction

    always @(negedge clock) begin
        obs_t o;
        if (reset) begin
            m_k = 0;
            m_bits = '0;
            exp_q.delete();
        end else begin
            if (output_strobe) begin
                o.bits = out_bits;
                o.cyc = cyc;
                obs.push_back(o);
                n_cmp++;
                if (!(output_ready && enable)) begin
                    n_bad++;
                    $display("FAIL strobe_qual: strobe=1 with output_ready=%b enable=%b, required both 1",
                             output_ready, enable);
                end
            end
            if (enable && input_strobe && in_ready) begin
                if (m_k == 0) m_rate = rate;
                m_bits[m_k] = in_bit;
                m_k++;
                n_acc++;
                last_acc = cyc;
                if (m_k == ncbps_of(m_rate)) begin
                    build_exp(m_rate, m_bits);
                    m_k = 0;
                    m_bits = '0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic send_bits(input logic [7:0] r0, input logic [7:0] r1, input int sw,
                             input logic [311:0] b, input int n);
        for (int idx = 0; idx < n; idx++) begin
            rate = (idx < sw) ? r0 : r1;
            in_bit = b[idx];
            input_strobe = 1'b1;
            tick();
        end
        input_strobe = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while (obs.size() < exp_q.size() && c < budget) begin
            tick();
            c++;
        end
        repeat (20) tick();
    endtask

    task automatic check_sb(input string name, input bit partial);
        int n;
        n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        if (partial) check({name, "_count"}, int'(obs.size() <= exp_q.size()), 1);
        else check({name, "_count"}, obs.size(), exp_q.size());
        for (int q = 0; q < n; q++)
            check($sformatf("%s[%0d]", name, q), int'(obs[q].bits), int'(exp_q[q]));
        repeat (n) begin
            void'(obs.pop_front());
            void'(exp_q.pop_front());
        end
        if (!partial) begin
            obs.delete();
            exp_q.delete();
        end
    endtask

    function automatic logic [311:0] rand_bits();
        logic [311:0] b;
        for (int q = 0; q < 312; q++) b[q] = 1'($urandom_range(0, 1));
        return b;
    endfunction

    typedef struct {
        logic [7:0] rate;
        int         kset;
        int         nbits;
        int         nsc;
        int         exp_sc;
        logic [5:0] exp_bits;
        int         lat;
        int         gap;
    } vec_t;

    vec_t         tbl[6];
    logic [311:0] b;
    int           acc0, c, lat, gap;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h0B, 1, 48, 48, 3, 6'b000001, 3, 2};
        tbl[1] = '{8'h09, 1, 192, 48, 3, 6'b000010, 6, 5};
        tbl[2] = '{8'h87, 1, 312, 52, 4, 6'b000100, 8, 7};
        tbl[3] = '{8'h0A, 5, 96, 48, 15, 6'b000001, 4, 3};
        tbl[4] = '{8'h83, 14, 208, 52, 4, 6'b000001, 6, 5};
        tbl[5] = '{8'h0C, 20, 288, 48, 12, 6'b000001, 8, 7};

        reset = 1'b1; enable = 1'b1; rate = 8'h00; in_bit = 1'b0;
        input_strobe = 1'b0; output_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_strobe", int'(output_strobe), 0);
        check("rst_out_bits", int'(out_bits), 0);

        // Single-bit symbols with hand-computed destination subcarriers
        for (int t = 0; t < 6; t++) begin
            b = '0;
            b[tbl[t].kset] = 1'b1;
            obs.delete();
            send_bits(tbl[t].rate, tbl[t].rate, 0, b, tbl[t].nbits);
            wait_drain(3000);
            check($sformatf("tbl%0d_count", t), obs.size(), tbl[t].nsc);
            for (int q = 0; q < tbl[t].nsc; q++)
                check($sformatf("tbl%0d_sc%0d", t, q),
                      (q < obs.size()) ? int'(obs[q].bits) : -1,
                      (q == tbl[t].exp_sc) ? int'(tbl[t].exp_bits) : 0);
            lat = (obs.size() > 0) ? obs[0].cyc - last_acc : -1;
            gap = (obs.size() > 1) ? obs[1].cyc - obs[0].cyc : -1;
            check($sformatf("tbl%0d_latency", t), lat, tbl[t].lat);
            check($sformatf("tbl%0d_spacing", t), gap, tbl[t].gap);
            obs.delete();
            exp_q.delete();
        end

        // Back-to-back symbols with the mapper stalled: third symbol is dropped
        output_ready = 1'b0;
        acc0 = n_acc;
        send_bits(8'h0C, 8'h0C, 0, rand_bits(), 288);
        send_bits(8'h87, 8'h87, 0, rand_bits(), 312);
        check("b2b_in_ready_low", int'(in_ready), 0);
        send_bits(8'h0C, 8'h0C, 0, rand_bits(), 288);
        check("b2b_accepted", n_acc - acc0, 600);
        check("b2b_no_strobe_stalled", obs.size(), 0);
        output_ready = 1'b1;
        wait_drain(3000);
        check("b2b_in_ready_back", int'(in_ready), 1);
        check_sb("b2b", 1'b0);

        // Rate changed mid-symbol: first symbol stays legacy BPSK, next is HT MCS7
        send_bits(8'h0B, 8'h87, 20, rand_bits(), 48);
        send_bits(8'h87, 8'h87, 0, rand_bits(), 312);
        wait_drain(3000);
        check("rsw_strobes", obs.size(), 100);
        check_sb("rsw", 1'b0);

        // Random enable / output_ready / input_strobe activity over two symbols
        acc0 = n_acc;
        c = 0;
        while (n_acc - acc0 < 400 && c < 6000) begin
            enable = ($urandom_range(0, 3) != 0);
            output_ready = ($urandom_range(0, 9) < 7);
            input_strobe = ($urandom_range(0, 4) != 0);
            in_bit = 1'($urandom_range(0, 1));
            rate = (n_acc - acc0 < 192) ? 8'h09 : 8'h83;
            tick();
            c++;
        end
        input_strobe = 1'b0;
        check("rand_accepted", n_acc - acc0, 400);
        c = 0;
        while (obs.size() < exp_q.size() && c < 6000) begin
            enable = ($urandom_range(0, 3) != 0);
            output_ready = ($urandom_range(0, 9) < 7);
            tick();
            c++;
        end
        enable = 1'b1;
        output_ready = 1'b1;
        repeat (20) tick();
        check_sb("rand", 1'b0);

        // Reset while draining one symbol and filling the next
        send_bits(8'h0C, 8'h0C, 0, rand_bits(), 288);
        send_bits(8'h0C, 8'h0C, 0, rand_bits(), 100);
        check_sb("pre_reset", 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post_rst_in_ready", int'(in_ready), 1);
        check("post_rst_strobe", int'(output_strobe), 0);
        check("post_rst_out_bits", int'(out_bits), 0);
        obs.delete();
        exp_q.delete();
        repeat (60) tick();
        check("post_rst_quiet", obs.size(), 0);
        send_bits(8'h87, 8'h87, 0, rand_bits(), 312);
        wait_drain(3000);
        check_sb("post_reset", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
